test_pattern_render: RTL and testbench
======================================

Name: test_pattern_render

Overview:
- Bring-up substitute for render_module on the framebuffer's render-side write port.
- Sweeps every pixel of a frame in raster order and writes a selectable test pattern into the back buffer.
- Uses the render_done/render_ack handshake so the framebuffer swaps buffers exactly as it does for the real renderer.
- Used to validate the framebuffer and output path independently of the voxel renderer.

Parameters:
- H_RES, 320, pixels per line; must be a multiple of 8, ≤512.
- V_RES, 240, lines per frame; ≤256.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  synchronous, active-low reset.
- enable  in  1  when low, pixel sweep stalls in place.
- pattern_sel  in  2  0=solid, 1=color bars, 2=checkerboard, 3=scrolling stripes.
- solid_color  in  3  color used by pattern 0.
- render_ack  in  1  framebuffer acknowledges completed frame (buffer swapped).
- coord_x  out  9  write x coordinate.
- coord_y  out  8  write y coordinate.
- color_out  out  3  write color, RGB 1 bit each.
- framebuffer_we  out  1  write strobe; coords/color valid same cycle.
- render_done  out  1  frame complete, awaiting ack.
- busy  out  1  high in DRAW.
- frame_count  out  8  completed-and-acked frames, wraps 255→0.

Behaviour:
- Reset (Reset_n=0 sampled on a rising Clk edge, including mid-frame):
  - state=IDLE; coord_x=0, coord_y=0, color_out=0, framebuffer_we=0, render_done=0, busy=0, frame_count=0.
  - Any partial frame is abandoned.
- State IDLE:
  - One cycle.
  - Latch pattern_sel and solid_color into frame-local registers; changes mid-frame are ignored.
  - Clear x/y counters; go to DRAW.
- State DRAW:
  - busy=1.
  - Each cycle with enable=1: framebuffer_we=1 with the current (x,y) and its color, then advance.
  - Advance rule: x++; at x=H_RES-1, x←0 and y++.
  - Each cycle with enable=0: framebuffer_we=0; x, y and the bar counter hold.
  - Writing pixel (H_RES-1, V_RES-1) → next state DONE.
  - Exactly H_RES*V_RES strobes per frame; each pixel is written exactly once.
- State DONE:
  - render_done=1, framebuffer_we=0; render_done holds until render_ack=1 is sampled.
  - On that edge: frame_count++, render_done←0, state←IDLE.
  - render_ack high on the cycle DONE is entered is honoured (single DONE cycle).
  - render_ack outside DONE is ignored.
- Pattern color, combinational from the registered (x,y), registered into color_out alongside the coords:
  - 0 solid: solid_color.
  - 1 bars: bar index 0..7, incremented every H_RES/8 pixels along a line, reset at x=0. Color = bar index, so bar 0=black and bar 7=white. Implemented with a counter; no divider.
  - 2 checker: (x[3]^y[3]) ? 3'b111 : 3'b000.
  - 3 stripes: sum = x + y + frame_count, computed 10 bits wide; color = sum[5:3]. frame_count is the value latched at IDLE. Stripes scroll one pixel per frame.
- Counter widths: x 9 bits, y 8 bits. No wrap occurs because the terminal pixel triggers DONE.
- Reset has priority over all other inputs.

Optional Feature:
- Macro: TEST_PATTERN_BORDER_EN.
- Defined: pixels with x=0, x=H_RES-1, y=0 or y=V_RES-1 are forced to color 3'b111, overriding every pattern. This is used to verify edge alignment and overscan on the VGA output.
- Undefined: no border logic is synthesized; edge pixels follow the pattern.

Test Plan:
- H_RES=16, V_RES=4, pattern 0, solid_color=3'b101, enable=1 → 64 consecutive strobes (0,0)…(15,3), all color 5. render_done rises the cycle after (15,3) and holds 10 cycles until ack is pulsed, then drops; frame_count=1.
- Pattern 1 at H_RES=16 → colors per line 0,0,1,1,…,7,7; pattern repeats identically on every line.
- Pattern 3 across 3 acked frames → pixel (0,0) is written with 0, then (0+0+1)[5:3]=0. Pixel (7,0) in frame 1 has sum 8, giving color 1.
- Toggle enable low for 5 cycles at pixel (9,2) → no strobes during the stall, resume at (9,2), no pixel duplicated or skipped; total strobes still 64.
- Assert Reset_n=0 at pixel (5,1) → next cycle all outputs are 0 and frame_count=0. After release, the frame restarts at (0,0).
- With TEST_PATTERN_BORDER_EN, pattern 2 → pixels in row 0, row 3, column 0 and column 15 are 7; pixel (1,1) is 0 (the checker value).

Source files
------------

// File: rtl/test_pattern_render.sv
// Test-pattern renderer: sweeps a frame in raster order writing a selectable pattern,
// then hands off via render_done/render_ack. Define TEST_PATTERN_BORDER_EN for a white frame border.
module test_pattern_render #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  input  logic [2:0] solid_color,
  input  logic       render_ack,
  output logic [8:0] coord_x,
  output logic [7:0] coord_y,
  output logic [2:0] color_out,
  output logic       framebuffer_we,
  output logic       render_done,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam logic [8:0] X_LAST   = 9'(H_RES - 1);
  localparam logic [7:0] Y_LAST   = 8'(V_RES - 1);
  localparam logic [5:0] BAR_LAST = 6'(H_RES / 8 - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  logic [5:0] bar_cnt_q, bar_cnt_d;
  logic [1:0] pat_q, pat_d;
  logic [2:0] solid_q, solid_d;
  logic [8:0] coord_x_q, coord_x_d;
  logic [7:0] coord_y_q, coord_y_d;
  logic [2:0] color_q, color_d;
  logic       we_q, we_d;
  logic       done_q, done_d;
  logic [7:0] fc_q, fc_d;

  logic [5:0] stripe_sum;
  logic [2:0] pix;

  always_comb begin
    // Only sum[5:3] is visible, and those bits depend only on the low 6 bits of each term.
    stripe_sum = x_q[5:0] + y_q[5:0] + fc_q[5:0];
    case (pat_q)
      2'd0:    pix = solid_q;
      2'd1:    pix = bar_idx_q;
      2'd2:    pix = (x_q[3] ^ y_q[3]) ? '1 : '0;
      default: pix = stripe_sum[5:3];
    endcase
`ifdef TEST_PATTERN_BORDER_EN
    if (x_q == '0 || x_q == X_LAST || y_q == '0 || y_q == Y_LAST) pix = '1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_idx_d = bar_idx_q;
    bar_cnt_d = bar_cnt_q;
    pat_d     = pat_q;
    solid_d   = solid_q;
    coord_x_d = coord_x_q;
    coord_y_d = coord_y_q;
    color_d   = color_q;
    we_d      = 1'b0;
    done_d    = done_q;
    fc_d      = fc_q;
    case (state_q)
      S_IDLE: begin
        pat_d     = pattern_sel;
        solid_d   = solid_color;
        x_d       = '0;
        y_d       = '0;
        bar_idx_d = '0;
        bar_cnt_d = '0;
        done_d    = 1'b0;
        state_d   = S_DRAW;
      end
      S_DRAW: begin
        if (enable) begin
          we_d      = 1'b1;
          coord_x_d = x_q;
          coord_y_d = y_q;
          color_d   = pix;
          if (x_q == X_LAST) begin
            x_d       = '0;
            bar_idx_d = '0;
            bar_cnt_d = '0;
            if (y_q == Y_LAST) state_d = S_DONE;
            else               y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 9'd1;
            if (bar_cnt_q == BAR_LAST) begin
              bar_cnt_d = '0;
              bar_idx_d = bar_idx_q + 3'd1;
            end else begin
              bar_cnt_d = bar_cnt_q + 6'd1;
            end
          end
        end
      end
      S_DONE: begin
        // render_done appears one cycle after the last strobe; an ack on DONE entry still counts.
        if (render_ack) begin
          fc_d    = fc_q + 8'd1;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      bar_idx_q <= '0;
      bar_cnt_q <= '0;
      pat_q     <= '0;
      solid_q   <= '0;
      coord_x_q <= '0;
      coord_y_q <= '0;
      color_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_idx_q <= bar_idx_d;
      bar_cnt_q <= bar_cnt_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      coord_x_q <= coord_x_d;
      coord_y_q <= coord_y_d;
      color_q   <= color_d;
      we_q      <= we_d;
      done_q    <= done_d;
      fc_q      <= fc_d;
    end
  end

  assign coord_x        = coord_x_q;
  assign coord_y        = coord_y_q;
  assign color_out      = color_q;
  assign framebuffer_we = we_q;
  assign render_done    = done_q;
  assign busy           = (state_q == S_DRAW);
  assign frame_count    = fc_q;

endmodule

// File: tb/tb_test_pattern_render.sv
// Randomized self-checking bench for test_pattern_render on a 16x4 frame.
module tb_test_pattern_render;

  localparam int H = 16;
  localparam int V = 4;
  localparam int NPIX = H * V;
  localparam int BUDGET = NPIX * 8 + 50;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       enable;
  logic [1:0] pattern_sel;
  logic [2:0] solid_color;
  logic       render_ack;
  logic [8:0] coord_x;
  logic [7:0] coord_y;
  logic [2:0] color_out;
  logic       framebuffer_we;
  logic       render_done;
  logic       busy;
  logic [7:0] frame_count;

  int tests = 0;
  int fails = 0;
  int fc_model = 0;

  test_pattern_render #(.H_RES(H), .V_RES(V)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .render_ack(render_ack), .coord_x(coord_x),
    .coord_y(coord_y), .color_out(color_out), .framebuffer_we(framebuffer_we),
    .render_done(render_done), .busy(busy), .frame_count(frame_count)
  );

  initial forever #5 Clk = ~Clk;

  function automatic logic [2:0] exp_color(input int pat, input logic [2:0] solid,
                                           input int x, input int y, input int fc);
    logic [2:0] c;
    case (pat)
      0:       c = solid;
      1:       c = 3'(x / (H / 8));
      2:       c = (((x / 8) % 2) != ((y / 8) % 2)) ? 3'd7 : 3'd0;
      default: c = 3'(((x + y + fc) / 8) % 8);
    endcase
`ifdef TEST_PATTERN_BORDER_EN
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) c = 3'd7;
`endif
    return c;
  endfunction

  task automatic run_frame(input int pat, input logic [2:0] solid, input bit rand_en,
                           input bit rand_ack, input int stall_at, input int stall_len,
                           input int ack_delay, input int reset_at);
    int idx = 0;
    int cyc = 0;
    bit stalled = 0;
    int px, py;
    logic [2:0] ec;
    pattern_sel = 2'(pat);
    solid_color = solid;
    enable = 1'b1;
    render_ack = 1'b0;
    while (idx < NPIX && cyc < BUDGET) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++; $display("FAIL busy_draw: got %b want 1", busy);
        end
      end
      tests++;
      if (render_done !== 1'b0) begin
        fails++; $display("FAIL done_in_draw idx=%0d: got %b want 0", idx, render_done);
      end
      if (framebuffer_we === 1'b1) begin
        px = idx % H;
        py = idx / H;
        ec = exp_color(pat, solid, px, py, fc_model);
        tests++;
        if (coord_x !== 9'(px) || coord_y !== 8'(py) || color_out !== ec) begin
          fails++;
          $display("FAIL pixel pat=%0d: got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                   pat, coord_x, coord_y, color_out, px, py, ec);
        end
        idx++;
        if (idx == reset_at) begin
          Reset_n = 1'b0;
          return;
        end
      end
      enable = rand_en ? ($urandom_range(3) != 0) : 1'b1;
      if (rand_ack) render_ack = 1'($urandom_range(1));
      pattern_sel = 2'($urandom);
      solid_color = 3'($urandom);
      if (stall_at >= 0 && !stalled && idx == stall_at) begin
        stalled = 1;
        enable = 1'b0;
        repeat (stall_len) begin
          @(negedge Clk);
          cyc++;
          tests++;
          if (framebuffer_we !== 1'b0) begin
            fails++; $display("FAIL stall_we: got %b want 0", framebuffer_we);
          end
        end
        enable = 1'b1;
      end
    end
    tests++;
    if (idx < NPIX) begin
      fails++;
      $display("FAIL frame_timeout: got %0d strobes want %0d", idx, NPIX);
      return;
    end
    if (render_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_entry: got done=%b busy=%b want 0/0", render_done, busy);
    end
    enable = 1'b1;
    if (ack_delay == 0) begin
      render_ack = 1'b1;
    end else begin
      render_ack = 1'b0;
      @(negedge Clk);
      tests++;
      if (render_done !== 1'b1) begin
        fails++; $display("FAIL done_rise: got %b want 1", render_done);
      end
      repeat (ack_delay - 1) begin
        @(negedge Clk);
        tests++;
        if (render_done !== 1'b1 || framebuffer_we !== 1'b0 || frame_count !== 8'(fc_model)) begin
          fails++;
          $display("FAIL done_hold: got done=%b we=%b fc=%0d want 1/0/%0d",
                   render_done, framebuffer_we, frame_count, fc_model);
        end
      end
      render_ack = 1'b1;
    end
    @(negedge Clk);
    render_ack = 1'b0;
    fc_model = (fc_model + 1) % 256;
    tests++;
    if (render_done !== 1'b0 || framebuffer_we !== 1'b0 || frame_count !== 8'(fc_model)) begin
      fails++;
      $display("FAIL ack: got done=%b we=%b fc=%0d want 0/0/%0d",
               render_done, framebuffer_we, frame_count, fc_model);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (coord_x !== 9'd0 || coord_y !== 8'd0 || color_out !== 3'd0 || framebuffer_we !== 1'b0 ||
        render_done !== 1'b0 || busy !== 1'b0 || frame_count !== 8'd0) begin
      fails++;
      $display("FAIL %s: got x=%0d y=%0d c=%0d we=%b done=%b busy=%b fc=%0d want all 0",
               name, coord_x, coord_y, color_out, framebuffer_we, render_done, busy, frame_count);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    enable = 1'b1;
    pattern_sel = 2'd0;
    solid_color = 3'd0;
    render_ack = 1'b0;
    repeat (3) @(negedge Clk);
    check_zero("reset");
    Reset_n = 1'b1;
    fc_model = 0;
  endtask

  task automatic test_solid();
    run_frame(0, 3'b101, 0, 0, -1, 0, 10, -1);
  endtask

  task automatic test_bars();
    run_frame(1, 3'($urandom), 0, 0, -1, 0, 2, -1);
  endtask

  task automatic test_stripes();
    run_frame(3, 3'd0, 0, 0, -1, 0, 0, -1);
    run_frame(3, 3'd0, 0, 0, -1, 0, 1, -1);
    run_frame(3, 3'd0, 1, 0, -1, 0, 3, -1);
  endtask

  task automatic test_checker();
    run_frame(2, 3'($urandom), 0, 0, -1, 0, 1, -1);
  endtask

  task automatic test_stall();
    run_frame(0, 3'b010, 0, 0, 2 * H + 9, 5, 1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_frame(int'($urandom_range(3)), 3'($urandom), 1, 1, -1, 0,
                int'($urandom_range(4)), -1);
  endtask

  task automatic test_reset_midframe();
    run_frame(int'($urandom_range(3)), 3'($urandom), 0, 1, -1, 0, 0, H + 6);
    @(negedge Clk);
    check_zero("midframe_reset");
    @(negedge Clk);
    check_zero("reset_hold");
    Reset_n = 1'b1;
    fc_model = 0;
    run_frame(0, 3'b011, 1, 1, -1, 0, 2, -1);
  endtask

  initial begin
    test_reset();
    test_solid();
    test_bars();
    test_stripes();
    test_checker();
    test_stall();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
